mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 71 +++++++
 rtl/mc_decode.sv | 66 ++++++
 rtl/mc_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle controller: instruction codes, ALU/memory/PC
// mode codes, datapath select codes, FSM state encodings and the decoded-control record.
package mc_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [5:0] ALU_ADDU = 6'd0;
    localparam logic [5:0] ALU_SUBU = 6'd1;
    localparam logic [5:0] ALU_OR   = 6'd2;
    localparam logic [5:0] ALU_LUI  = 6'd3;
    localparam logic [5:0] ALU_EQU  = 6'd4;

    localparam logic [2:0] MEM_NEG  = 3'd0;
    localparam logic [2:0] MEM_SW   = 3'd1;
    localparam logic [2:0] MEM_SB   = 3'd2;

    localparam logic [2:0] MODE_NORM   = 3'd0;
    localparam logic [2:0] MODE_LOGI   = 3'd1;
    localparam logic [2:0] MODE_JMODE  = 3'd2;
    localparam logic [2:0] MODE_JRMODE = 3'd3;

    // Datapath mux select codes, shared with the single-cycle controller.
    localparam logic [2:0] A_RS       = 3'd0;
    localparam logic [2:0] A_PC       = 3'd1;
    localparam logic [2:0] B_RT       = 3'd0;
    localparam logic [2:0] B_IMM_ZEXT = 3'd1;
    localparam logic [2:0] B_IMM_SEXT = 3'd2;
    localparam logic [2:0] B_FOUR     = 3'd3;
    localparam logic [2:0] WT_RD      = 3'd0;
    localparam logic [2:0] WT_RT      = 3'd1;
    localparam logic [2:0] WT_RA      = 3'd2;
    localparam logic [2:0] WD_ALU     = 3'd0;
    localparam logic [2:0] WD_MEM     = 3'd1;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_JR, I_ORI, I_LW, I_SW, I_SB, I_BEQ, I_LUI, I_JAL, I_UNK
    } instr_t;

    typedef struct packed {
        instr_t     instr;
        logic [5:0] alu_op;
        logic [2:0] a_sel;
        logic [2:0] b_sel;
        logic [2:0] wt_sel;
        logic [2:0] wd_sel;
    } decode_t;

    function automatic logic is_mem_instr(input instr_t i);
        return (i == I_LW) || (i == I_SW) || (i == I_SB);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func decode into instruction class, ALU operation and datapath selects.
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output decode_t    dec
);

    always_comb begin
        // NOTE: the full default first keeps every field assigned on every path, so no latch is inferred.
        dec = '{instr: I_UNK, alu_op: ALU_ADDU, a_sel: A_RS, b_sel: B_RT, wt_sel: WT_RD, wd_sel: WD_ALU};
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: dec.instr = I_ADD;
                    FN_SUB: begin
                        dec.instr  = I_SUB;
                        dec.alu_op = ALU_SUBU;
                    end
                    FN_JR:  dec.instr = I_JR;
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.instr  = I_ORI;
                dec.alu_op = ALU_OR;
                dec.b_sel  = B_IMM_ZEXT;
                dec.wt_sel = WT_RT;
            end
            OP_LUI: begin
                dec.instr  = I_LUI;
                dec.alu_op = ALU_LUI;
                dec.b_sel  = B_IMM_ZEXT;
                dec.wt_sel = WT_RT;
            end
            OP_LW: begin
                dec.instr  = I_LW;
                dec.b_sel  = B_IMM_SEXT;
                dec.wt_sel = WT_RT;
                dec.wd_sel = WD_MEM;
            end
            OP_SW: begin
                dec.instr = I_SW;
                dec.b_sel = B_IMM_SEXT;
            end
            OP_SB: begin
                dec.instr = I_SB;
                dec.b_sel = B_IMM_SEXT;
            end
            OP_BEQ: begin
                dec.instr  = I_BEQ;
                dec.alu_op = ALU_EQU;
            end
            OP_JAL: begin
                // Link address pc+4 is formed by the ALU and written to $31.
                dec.instr  = I_JAL;
                dec.a_sel  = A_PC;
                dec.b_sel  = B_FOUR;
                dec.wt_sel = WT_RA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller: IF/ID/EX/MEM/WB sequencing with memory handshake and a retire counter.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        memReady,
    output logic        memReq,
    output logic        irWE,
    output logic        pcWE,
    output logic        grfWE,
    output logic [2:0]  memWrite,
    output logic [5:0]  aluOp,
    output logic [2:0]  mode,
    output logic [2:0]  AChoose,
    output logic [2:0]  BChoose,
    output logic [2:0]  wtChoose,
    output logic [2:0]  wdataChoose,
    output logic [2:0]  state,
    output logic        instrDone,
    output logic [31:0] instCount
);

    state_t     cur;
    state_t     nxt;
    logic [4:0] st_hot;
    decode_t    dec;

    mc_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .dec    (dec)
    );

    assign st_hot      = 5'b00001 << cur;
    assign state       = cur;
    assign aluOp       = dec.alu_op;
    assign AChoose     = dec.a_sel;
    assign BChoose     = dec.b_sel;
    assign wtChoose    = dec.wt_sel;
    assign wdataChoose = dec.wd_sel;
    assign instrDone   = pcWE;

    // Enables depend on memReady in the same cycle, so they are decoded combinationally.
    always_comb begin
        nxt      = cur;
        memReq   = 1'b0;
        irWE     = 1'b0;
        pcWE     = 1'b0;
        grfWE    = 1'b0;
        memWrite = MEM_NEG;
        mode     = MODE_NORM;
        if (!reset) begin
            case (1'b1)
                st_hot[S_IF]: begin
                    memReq = 1'b1;
                    if (memReady) begin
                        irWE = 1'b1;
                        nxt  = S_ID;
                    end
                end
                st_hot[S_ID]: begin
                    if (dec.instr == I_UNK) begin
                        pcWE = 1'b1;
                        nxt  = S_IF;
                    end else begin
                        nxt  = S_EX;
                    end
                end
                st_hot[S_EX]: begin
                    if (dec.instr == I_BEQ) begin
                        pcWE = 1'b1;
                        mode = MODE_LOGI;
                        nxt  = S_IF;
                    end else if (dec.instr == I_JR) begin
                        pcWE = 1'b1;
                        mode = MODE_JRMODE;
                        nxt  = S_IF;
                    end else if (is_mem_instr(dec.instr)) begin
                        nxt  = S_MEM;
                    end else begin
                        nxt  = S_WB;
                    end
                end
                st_hot[S_MEM]: begin
                    memReq = 1'b1;
                    if (memReady) begin
                        if (dec.instr == I_LW) begin
                            nxt = S_WB;
                        end else begin
                            memWrite = (dec.instr == I_SW) ? MEM_SW : MEM_SB;
                            pcWE     = 1'b1;
                            nxt      = S_IF;
                        end
                    end
                end
                st_hot[S_WB]: begin
                    grfWE = 1'b1;
                    pcWE  = 1'b1;
                    mode  = (dec.instr == I_JAL) ? MODE_JMODE : MODE_NORM;
                    nxt   = S_IF;
                end
                default: nxt = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cur       <= S_IF;
            instCount <= '0;
        end else begin
            cur <= nxt;
            if (pcWE) begin
                instCount <= instCount + 32'd1;
            end
        end
    end

endmodule
